// File: rtl/vga_pkg.sv
// Shared VGA timing and colour constants for the timing generator and pixel generators.
package vga_pkg;

    typedef logic [10:0] coord_t;
    typedef logic [7:0]  rgb_t;

    localparam int DEF_CLK_DIV   = 4;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Colour byte layout is [B|G|R] = 2:3:3 bits.
    localparam rgb_t BLACK  = 8'h00;
    localparam rgb_t WHITE  = 8'hFF;
    localparam rgb_t RED    = 8'h07;
    localparam rgb_t GREEN  = 8'h38;
    localparam rgb_t BLUE   = 8'hC0;
    localparam rgb_t YELLOW = 8'h3F;

    function automatic logic in_window(input coord_t val, input int lo, input int hi);
        return (int'(val) >= lo) && (int'(val) <= hi);
    endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// Divides the system clock down to the pixel rate and emits a one-clk pixel strobe.
module vga_pixel_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pixel_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign pixel_en = (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync decode and registered colour output; outputs lag
// xCoord/yCoord by exactly one pixel period.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rgb_in,
    output logic [10:0] xCoord,
    output logic [10:0] yCoord,
    output logic        pixel_en,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start,
    output logic [7:0]  rgb
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   video_on_q, video_on_d;
    rgb_t   rgb_q, rgb_d;
    logic   h_wrap;
    logic   v_wrap;

    vga_pixel_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_div (
        .clk      (clk),
        .rst      (rst),
        .pixel_en (pixel_en)
    );

    // Sync/colour decode uses the pre-increment counts, giving the fixed one-pixel lag.
    always_comb begin
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        video_on_d = video_on_q;
        rgb_d      = rgb_q;
        h_wrap     = (h_cnt_q == H_LAST);
        v_wrap     = (v_cnt_q == V_LAST);
        if (pixel_en) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 11'd1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 11'd1;
            end
            hsync_d    = !in_window(h_cnt_q, HS_START, HS_END);
            vsync_d    = !in_window(v_cnt_q, VS_START, VS_END);
            video_on_d = (int'(h_cnt_q) < H_VISIBLE) && (int'(v_cnt_q) < V_VISIBLE);
            rgb_d      = video_on_d ? rgb_in : BLACK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
            rgb_q      <= BLACK;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
            rgb_q      <= rgb_d;
        end
    end

    assign frame_start = pixel_en && h_wrap && v_wrap;
    assign xCoord      = h_cnt_q;
    assign yCoord      = v_cnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 15x8 raster (8x4 visible, CLK_DIV=4).
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rgb_const = 8'h00;
    logic [7:0]  rgb_pipe = 8'h00;
    logic        align_mode = 1'b0;
    logic [7:0]  rgb_in;
    logic [10:0] xCoord, yCoord;
    logic        pixel_en, hsync, vsync, video_on, frame_start;
    logic [7:0]  rgb;

    int n_cmp = 0;
    int n_bad = 0;

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in), .xCoord(xCoord), .yCoord(yCoord),
        .pixel_en(pixel_en), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .frame_start(frame_start), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Models a pixel source with one clk of latency.
    always @(posedge clk) rgb_pipe <= xCoord[7:0];
    assign rgb_in = align_mode ? rgb_pipe : rgb_const;

    task automatic apply_reset(input int hold);
        @(negedge clk);
        rst = 1'b1;
        repeat (hold) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_xy(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (xCoord == 11'(x) && yCoord == 11'(y)) begin
                ok = 1'b1;
                break;
            end
        end
        check_bit($sformatf("wait_xy_%0d_%0d", x, y), ok, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check_int({tag, "_x"}, int'(xCoord), 0);
        check_int({tag, "_y"}, int'(yCoord), 0);
        check_bit({tag, "_pixel_en"}, pixel_en, 1'b0);
        check_bit({tag, "_frame_start"}, frame_start, 1'b0);
        check_bit({tag, "_hsync"}, hsync, 1'b1);
        check_bit({tag, "_vsync"}, vsync, 1'b1);
        check_bit({tag, "_video_on"}, video_on, 1'b0);
        check_int({tag, "_rgb"}, int'(rgb), 0);
    endtask

    task automatic check_restart(input string tag);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check_bit($sformatf("%s_pe_k%0d", tag, k), pixel_en, k == 3);
            check_int($sformatf("%s_x_k%0d", tag, k), int'(xCoord), (k >= 4) ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        rgb_const = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check_bit($sformatf("release_pe_k%0d", k), pixel_en, k == 3);
            check_int($sformatf("release_x_k%0d", k), int'(xCoord), (k >= 4) ? 1 : 0);
            check_bit($sformatf("release_hsync_k%0d", k), hsync, 1'b1);
            check_bit($sformatf("release_vsync_k%0d", k), vsync, 1'b1);
            check_int($sformatf("release_rgb_k%0d", k), int'(rgb), 0);
        end
    endtask

    task automatic test_line_timing();
        int last_pe = -1;
        int hs_low = 0;
        int fall_x = -1;
        int wrap_k[$];
        logic hs_prev = 1'b1;
        apply_reset(2);
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            if (pixel_en) begin
                if (last_pe < 0) check_int("line_first_pe", k, 3);
                else check_int($sformatf("line_pe_period_k%0d", k), k - last_pe, CLK_DIV);
                last_pe = k;
                if (xCoord == 11'(HV + HF + HS + HB - 1)) wrap_k.push_back(k);
            end
            if (k <= 60 && !hsync) hs_low++;
            if (hs_prev && !hsync && fall_x < 0) fall_x = int'(xCoord);
            hs_prev = hsync;
        end
        check_int("line_hsync_low_clks", hs_low, 12);
        check_int("line_hsync_fall_x", fall_x, 11);
        check_int("line_wrap_count", wrap_k.size(), 2);
        if (wrap_k.size() == 2) begin
            check_int("line_first_wrap_k", wrap_k[0], 59);
            check_int("line_period_clks", wrap_k[1] - wrap_k[0], 60);
        end
    endtask

    task automatic test_frame_timing();
        int fs_k[$];
        int pe_cnt = 0;
        int vs_low = 0;
        int vs_first = -1;
        bit after_fs = 1'b0;
        apply_reset(2);
        for (int k = 1; k <= 970; k++) begin
            @(negedge clk);
            if (after_fs) begin
                check_int($sformatf("frame_wrap_x_k%0d", k), int'(xCoord), 0);
                check_int($sformatf("frame_wrap_y_k%0d", k), int'(yCoord), 0);
                after_fs = 1'b0;
            end
            if (frame_start) begin
                fs_k.push_back(k);
                check_int($sformatf("frame_fs_x_k%0d", k), int'(xCoord), 14);
                check_int($sformatf("frame_fs_y_k%0d", k), int'(yCoord), 7);
                check_bit($sformatf("frame_fs_pe_k%0d", k), pixel_en, 1'b1);
                after_fs = 1'b1;
            end
            if (k <= 480) begin
                if (pixel_en) pe_cnt++;
                if (!vsync) begin
                    vs_low++;
                    if (vs_first < 0) vs_first = k;
                end
            end
        end
        check_int("frame_pe_per_frame", pe_cnt, 120);
        check_int("frame_vsync_low_clks", vs_low, 120);
        check_int("frame_vsync_fall_k", vs_first, 304);
        check_int("frame_start_count", fs_k.size(), 2);
        if (fs_k.size() == 2) begin
            check_int("frame_start_first_k", fs_k[0], 479);
            check_int("frame_period_clks", fs_k[1] - fs_k[0], 480);
        end
    endtask

    task automatic test_blanking();
        int vis = 0;
        int vid = 0;
        int bad = 0;
        rgb_const = WHITE;
        apply_reset(2);
        for (int k = 1; k <= 480; k++) begin
            @(negedge clk);
            if (video_on) vid++;
            if (video_on && rgb == 8'hFF) vis++;
            if (video_on ? (rgb != 8'hFF) : (rgb != 8'h00)) bad++;
        end
        check_int("blank_visible_clks", vis, 128);
        check_int("blank_video_on_clks", vid, 128);
        check_int("blank_bad_rgb_clks", bad, 0);
        rgb_const = BLACK;
    endtask

    task automatic test_alignment();
        bit pend = 1'b0;
        logic exp_vid = 1'b0;
        logic [7:0] exp_rgb = 8'h00;
        align_mode = 1'b1;
        apply_reset(2);
        for (int k = 1; k <= 500; k++) begin
            @(negedge clk);
            if (pend) begin
                check_int($sformatf("align_rgb_k%0d", k), int'(rgb), int'(exp_rgb));
                check_bit($sformatf("align_video_on_k%0d", k), video_on, exp_vid);
            end
            pend = pixel_en;
            if (pixel_en) begin
                exp_vid = (int'(xCoord) < HV) && (int'(yCoord) < VV);
                exp_rgb = exp_vid ? xCoord[7:0] : 8'h00;
            end
        end
        align_mode = 1'b0;
    endtask

    task automatic test_mid_frame_reset();
        bit ok;
        rgb_const = WHITE;
        apply_reset(2);
        wait_xy(6, 2, ok);
        check_bit("mid_pre_video_on", video_on, 1'b1);
        check_int("mid_pre_rgb", int'(rgb), 255);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid_reset");
        rst = 1'b0;
        check_restart("mid_restart");
        wait_xy(12, 5, ok);
        check_bit("mid2_pre_hsync", hsync, 1'b0);
        check_bit("mid2_pre_vsync", vsync, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid2_reset");
        rst = 1'b0;
        check_restart("mid2_restart");
        rgb_const = BLACK;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_blanking();
        test_alignment();
        test_mid_frame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- CLK_DIV, 4, clk cycles per pixel; legal values are 2 and above.
- H_VISIBLE / H_FRONT / H_SYNC / H_BACK, 640 / 16 / 96 / 48, horizontal pixel counts.
- V_VISIBLE / V_FRONT / V_SYNC / V_BACK, 480 / 10 / 2 / 33, vertical line counts.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous active-high reset.
- rgb_in  input  8  pixel colour [B|G|R] from the pixel generator for the current xCoord/yCoord.
- xCoord  output  11  current horizontal count.
- yCoord  output  11  current vertical count.
- pixel_en  output  1  one-clk strobe marking the end of each pixel period.
- hsync  output  1  horizontal sync, active-low.
- vsync  output  1  vertical sync, active-low.
- video_on  output  1  high while rgb_out carries a visible pixel.
- frame_start  output  1  one-clk pulse per frame.
- rgb  output  8  colour to the DAC pins.

Function
REQ-004 Divider: div_cnt counts 0..CLK_DIV-1 and wraps; pixel_en SHALL be 1 exactly when div_cnt==CLK_DIV-1.
REQ-005 Horizontal counter: h_cnt SHALL advance on pixel_en and wrap from H_TOTAL-1 (799) to 0.
REQ-006 Vertical counter: v_cnt SHALL advance on the pixel_en where h_cnt wraps, and wrap from V_TOTAL-1 (524) to 0.
REQ-007 Counter width: both counters are 11-bit; H_TOTAL and V_TOTAL SHALL be derived as the sums of their four parameters.
REQ-008 Coordinates: xCoord=h_cnt and yCoord=v_cnt, driven directly from registers; each value is stable for CLK_DIV clks.
REQ-009 Blanking coordinates: out-of-visible values (x 640..799, y 480..524) SHALL be presented unmodified; the consumer performs bounds checks.
REQ-010 Output register: on each pixel_en, hsync, vsync, video_on and rgb SHALL be registered from the pre-increment h_cnt/v_cnt. This gives a fixed one-pixel lag relative to xCoord/yCoord.
REQ-011 hsync: SHALL be 0 for registered h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751], and 1 otherwise, independent of v.
REQ-012 vsync: SHALL be 0 for registered v in [490,491], and 1 otherwise.
REQ-013 video_on and rgb: video_on SHALL be (h<640 && v<480); rgb SHALL equal rgb_in when video_on, else 8'h00.
REQ-014 rgb_in timing: rgb_in SHALL be sampled only on the pixel_en clk, so a source with up to CLK_DIV-1 clk latency is captured correctly.
REQ-015 frame_start: SHALL be 1 for the single clk where pixel_en=1, h_cnt==799 and v_cnt==524.
REQ-016 Between pixel_en strobes, all outputs except pixel_en and frame_start SHALL hold their values.

Reset
REQ-017 When rst=1 at a clk edge: div_cnt, h_cnt and v_cnt SHALL be 0; hsync=1, vsync=1, video_on=0, rgb=0, pixel_en=0, frame_start=0.
REQ-018 Reset mid-frame SHALL abort the frame immediately; counting restarts at (0,0).
REQ-019 After reset, the first pixel_en SHALL occur on the CLK_DIV-th clk after rst deasserts.

Structure
REQ-020 Shared package vga_pkg SHALL hold the timing constants (640/480, porch and sync widths, totals) and the colour constants (BLACK, WHITE, RED, GREEN, BLUE, YELLOW). Pixel generators SHALL use these same constants.
REQ-021 One sub-module, vga_pixel_div (REQ-004 divider plus strobe), is natural. Counters, sync decode and the output register live in the top.

Verification
REQ-022 Reset release: rst held 3 clk then released -> pixel_en first high on clk 4 after release; xCoord 0->1 on that edge; hsync=vsync=1, rgb=0 throughout.
REQ-023 Line timing: one full line -> pixel_en period 4 clk; line period 3200 clk; hsync low for exactly 96 pixel periods, falling on the pixel_en where xCoord goes 656->657.
REQ-024 Frame timing: one full frame -> 1,680,000 clk per frame; vsync low 1600 pixel periods; exactly one frame_start, coincident with xCoord/yCoord wrapping to (0,0).
REQ-025 Blanking: rgb_in=8'hFF constant -> 307,200 pixel periods per frame with rgb=8'hFF and video_on=1; rgb=8'h00 in all others.
REQ-026 Alignment: rgb_in = xCoord[7:0] through a 1-clk register -> at every visible pixel_en, the next rgb equals the previous xCoord[7:0].
REQ-027 Mid-frame reset: rst asserted at (300,200) -> next clk shows all reset values; counting resumes from (0,0) per REQ-019.
